nibble_serial_sub: RTL
======================

Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor computing diff = a - b, one 4-bit nibble per clock, least significant nibble first.
- Each nibble is formed as a + ~b + carry using 4-bit generate/propagate carry-lookahead logic.
- The carry between nibbles is held in a register, so one small lookahead slice serves the full operand width.
- Sits beside the parallel nibble adders in the datapath as the area-lean subtract path, with a start/busy/done handshake to the controller.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibble cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  a - b, modulo 2^WIDTH
- borrow  output  1  unsigned borrow; 1 when a < b unsigned
- ovf  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- Decided interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: all registers clear immediately. State = IDLE; busy = 0, done = 0, diff = 0, borrow = 0, ovf = 0, zero = 0; internal nibble index = 0, carry = 0.
- States:
  - IDLE: start = 1 at a clock edge -> latch a and b, set carry = 1 (the +1 of two's complement), index = 0, clear diff, go to RUN.
  - RUN: each edge computes nibble index i:
    - p_j = a_j ^ ~b_j and g_j = a_j & ~b_j for the 4 bits of the nibble.
    - c1..c4 are derived in lookahead form from the registered carry.
    - diff nibble i = p ^ {c3, c2, c1, carry}.
    - carry <= c4; index <= index + 1.
    - When index = NIB-1 -> go to DONE.
  - DONE: exactly one cycle. done = 1 and busy = 0; flags are valid. Next edge -> IDLE.
- Latency:
  - start accepted at edge k.
  - busy = 1 from after edge k through edge k+NIB.
  - done = 1 for the single cycle after edge k+NIB. For WIDTH = 16 this is 4 RUN cycles, then the done pulse.
- Flags (registered on the last RUN edge, so valid when done rises):
  - borrow = ~c4 of the top nibble.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - zero = (full diff == 0).
- Hold: diff, borrow, ovf and zero hold their values in IDLE until the next accepted start. On that start they clear to 0.
- start while busy or in DONE: ignored, with no effect on the operation in flight. Changes to a and b after acceptance: no effect.
- start held high continuously: a new operation is accepted on each return to IDLE, giving back-to-back throughput of NIB+2 cycles per operation.
- Reset asserted mid-RUN: operation aborted, no done pulse, outputs return to reset values.
- Intermediate diff nibbles may be visible during RUN. Consumers sample diff only when done = 1.

Test Plan:
- WIDTH = 16, a = 0x1234, b = 0x0234, start one cycle -> busy for 4 cycles, then done pulse; diff = 0x1000, borrow = 0, ovf = 0, zero = 0.
- a = 0x0F00, b = 0x0001 (borrow ripples across nibble boundaries) -> diff = 0x0EFF, borrow = 0. Then a = 0x0000, b = 0x0001 -> diff = 0xFFFF, borrow = 1, ovf = 0, zero = 0.
- a = 0x8000, b = 0x0001 -> diff = 0x7FFF, ovf = 1, borrow = 0. Then a = 0x7FFF, b = 0xFFFF -> diff = 0x8000, ovf = 1, borrow = 1.
- a = 0x5A5A, b = 0x5A5A -> diff = 0x0000, zero = 1, borrow = 0, ovf = 0.
- Start 0x0009 - 0x0003. During RUN cycle 2, pulse start with a = 0xFFFF, b = 0x0000 -> ignored; exactly one done pulse, diff = 0x0006. Holding start high then gives a second done exactly 6 cycles after the first.
- Start an operation, then drop rst_n during RUN cycle 3 -> busy, done, diff and flags go to 0 immediately; no done pulse follows. After release, a fresh 0x0002 - 0x0001 -> diff = 0x0001.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub
//   Area-lean serial subtractor: diff = a - b, processed one 4-bit nibble per
//   clock, least significant nibble first. Each nibble is a + ~b + carry built
//   from a 4-bit generate/propagate lookahead slice; the inter-nibble carry is
//   registered so a single slice covers the full operand width.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request pulse, sampled only in IDLE
//   a, b    minuend / subtrahend, captured on an accepted start
//   busy    high while nibbles are being computed
//   done    one-cycle pulse when diff and flags are valid
//   diff    a - b modulo 2^WIDTH
//   borrow  unsigned borrow (a < b)
//   ovf     signed two's-complement overflow
//   zero    diff == 0
module nibble_serial_sub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry;
   logic [IW-1:0]    idx;

   // Lookahead slice for the current nibble
   int unsigned      base;
   logic [3:0]       an;
   logic [3:0]       bn;
   logic [3:0]       p;
   logic [3:0]       g;
   logic             c1;
   logic             c2;
   logic             c3;
   logic             c4;
   logic [3:0]       nib;
   logic [WIDTH-1:0] diff_next;

   always_comb begin
      base = 32'(idx) * 4;
      an   = a_r[base +: 4];
      bn   = b_r[base +: 4];
      // Subtraction: operate on ~b, the +1 comes in through the initial carry
      p    = an ^ ~bn;
      g    = an & ~bn;
      c1   = g[0] | (p[0] & carry);
      c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & carry);
      c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry);
      nib  = p ^ {c3, c2, c1, carry};
      // Full result as it will look after this edge; the flags on the last
      // nibble are derived from it so they are valid together with done.
      diff_next            = diff;
      diff_next[base +: 4] = nib;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r    <= a;
                  b_r    <= b;
                  carry  <= 1'b1;
                  idx    <= '0;
                  diff   <= '0;
                  borrow <= 1'b0;
                  ovf    <= 1'b0;
                  zero   <= 1'b0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               diff  <= diff_next;
               carry <= c4;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  borrow <= ~c4;
                  ovf    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                            (diff_next[WIDTH-1] != a_r[WIDTH-1]);
                  zero   <= (diff_next == '0);
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
